spi_sram_wb_slave: RTL and testbench
====================================

Name: spi_sram_wb_slave

Overview:
- Wishbone classic slave that serves byte reads and writes from the Levenshtein controller's Wishbone master.
- Each bus cycle becomes one SPI transaction to an external 23LC1024-class SRAM in byte mode (SPI mode 0, SCK = clk_i/2).
- Sits between the controller's master port and the chip's SPI pins. Covers the dictionary, bit-vector and result regions of the address map.

Parameters:
- ADDR_WIDTH, 24, Wishbone address width. Must be ≤ 24. Zero-extended to the 24-bit SPI address.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_adr_i  in  ADDR_WIDTH  byte address
- wbs_we_i  in  1  1 = write
- wbs_dat_i  in  8  write data
- wbs_ack_o  out  1  transfer done
- wbs_err_o  out  1  tied 0
- wbs_rty_o  out  1  tied 0
- wbs_dat_o  out  8  read data
- spi_cs_n_o  out  1  SRAM chip select, active low
- spi_sck_o  out  1  serial clock
- spi_mosi_o  out  1  master out
- spi_miso_i  in  1  master in

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values:
  - wbs_ack_o = 0, wbs_dat_o = 0x00
  - spi_cs_n_o = 1, spi_sck_o = 0, spi_mosi_o = 0
  - state = IDLE
- Reset asserted mid-transfer: CS, SCK and ack take their reset values immediately (asynchronous). The transaction is abandoned and no ack is issued.
- States and transitions:
  - IDLE → SHIFT on a clock edge where wbs_cyc_i & wbs_stb_i & !wbs_ack_o. This is the accept edge.
  - SHIFT → DONE after 40 bits.
  - DONE → IDLE after one cycle.
- Accept edge actions:
  - latch we, address (zero-extended to 24 bits) and wbs_dat_i
  - load shifter with the 40-bit frame {cmd, addr[23:0], data}; cmd = 0x03 for read, 0x02 for write; data = write byte, or 0x00 for reads
  - spi_cs_n_o <= 0
- SHIFT bit timing: each bit takes 2 clocks, MSB first.
  - Phase 0: SCK = 0, MOSI = current bit.
  - Phase 1: SCK = 1.
  - At the edge ending phase 1: sample spi_miso_i into the read byte (only during the final 8 bits) and advance the bit counter.
- Leaving SHIFT: at the edge ending bit 40, go to DONE. On that edge:
  - spi_cs_n_o <= 1, spi_sck_o <= 0
  - wbs_ack_o <= 1
  - wbs_dat_o <= assembled byte on reads; unchanged on writes
- Latency: wbs_ack_o is high exactly 81 edges after the accept edge, for exactly one cycle.
- Chip-select gap: CS stays high for at least 2 cycles between transactions (DONE + IDLE).
- Request changes: changes to wbs_adr_i, wbs_dat_i or wbs_we_i after the accept edge are ignored.
- Request withdrawal: dropping wbs_cyc_i before ack does not abort the SPI transfer. The ack is still pulsed and is harmless to the master.
- A request held high through the ack cycle is not re-accepted (gated by !wbs_ack_o).
- Address wrap: the SPI address is the latched value. No wrap logic is needed in byte mode.
- SCK is never high while spi_cs_n_o = 1.

Optional Feature:
- Macro: SPI_SRAM_SEQ_EN. Requires the SRAM to be preconfigured in sequential mode.
- With the macro defined:
  - After a transaction, the block enters HOLD instead of DONE→IDLE: CS stays low, SCK = 0, the last address and direction are kept, and ack is still pulsed once.
  - In HOLD, a new request with the same we and address == last + 1 (mod 2^24) shifts only the 8 data bits. Its ack comes 17 edges after the accept edge.
  - Any other request: CS goes high for 2 cycles, then a full 40-bit transaction runs. Ack comes 83 edges after the accept edge.
- Without the macro: no HOLD state, and every transaction is the full 40-bit form.

Decomposition:
- Package spi_sram_pkg:
  - CMD_READ = 8'h03, CMD_WRITE = 8'h02
  - FRAME_BITS = 40, DATA_BITS = 8
  - state enum: IDLE, SHIFT, DONE, HOLD
- Sub-module spi_sram_shifter:
  - 40-bit shift register, 6-bit bit counter and phase flag
  - generates SCK/MOSI and samples MISO
  - load/start inputs; done pulse output
- The top level holds the Wishbone FSM and CS control.

Test Plan:
1. Reset → hold rst_ni low, then release → ack = 0, cs_n = 1, sck = 0, and no SCK edges for 100 cycles while idle.
2. Write 0x5A to 0x000010 → MOSI bytes 02 00 00 10 5A on rising SCK; ack high exactly 81 edges after accept; cs_n = 1 the cycle after the ack.
3. Read 0x7FFFFF with SRAM model returning 0xA5 → MOSI 03 7F FF FF; wbs_dat_o = 0xA5 during ack.
4. Master-like stream (dict read, vector read, result write) → three frames with a CS-high gap ≥ 2 cycles; no duplicate ack; the held request is not re-accepted.
5. Pull rst_ni low at SHIFT bit 20 → cs_n = 1 and sck = 0 without waiting for a clock edge; no ack; the next write frame is correct.
6. With SPI_SRAM_SEQ_EN: reads of 0x100, 0x101, 0x200 → frames of 40, 8 and 40 bits; acks at 81, 17 and 83 edges after each accept.

Source files
------------

// File: rtl/spi_sram_wb_slave_pkg.sv
// Shared constants, FSM state type and SPI frame builder for the SPI SRAM Wishbone slave.
// Used by both the default build and the SPI_SRAM_SEQ_EN build.
package spi_sram_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam int         FRAME_BITS = 40;
    localparam int         DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Byte-mode frame: command, 24-bit address, data (0x00 on reads).
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic       we,
                                                          input logic [23:0] addr,
                                                          input logic [7:0]  data);
        return {(we ? CMD_WRITE : CMD_READ), addr, (we ? data : 8'h00)};
    endfunction

endpackage

// File: rtl/spi_sram_wb_slave_if.sv
// Wishbone classic slave-side bus bundle for the SPI SRAM slave.
// Handshake: a request is valid while wbs_cyc_i & wbs_stb_i; wbs_ack_o is the one-cycle ready/complete pulse.
interface spi_sram_wb_slave_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  wbs_cyc_i;
    logic                  wbs_stb_i;
    logic [ADDR_WIDTH-1:0] wbs_adr_i;
    logic                  wbs_we_i;
    logic [7:0]            wbs_dat_i;
    logic                  wbs_ack_o;
    logic                  wbs_err_o;
    logic                  wbs_rty_o;
    logic [7:0]            wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i,
        input  wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i,
        output wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_dat_o
    );
endinterface

// File: rtl/spi_sram_wb_slave_shifter.sv
// SPI mode-0 shifter: one lead cycle to present the MSB, then 2 clocks per bit, MSB first.
// The done pulse is asserted during the cycle whose closing edge finishes the last bit.
module spi_sram_shifter
    import spi_sram_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic [5:0]            nbits,
    input  logic                  miso,
    output logic                  sck,
    output logic                  mosi,
    output logic                  done,
    output logic [7:0]            rx_byte
);

    logic [FRAME_BITS-1:0] shreg;
    logic [5:0]            bits_left;
    logic                  phase;
    logic                  lead;
    logic                  active;
    logic [7:0]            rx_q;

    assign sck  = phase;
    assign done = active & ~lead & phase & (bits_left == 6'd1);
    // Includes the bit being sampled on the closing edge, so the top can latch it with done.
    assign rx_byte = {rx_q[6:0], miso};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg     <= '0;
            bits_left <= '0;
            phase     <= 1'b0;
            lead      <= 1'b0;
            active    <= 1'b0;
            mosi      <= 1'b0;
            rx_q      <= '0;
        end else if (load) begin
            shreg     <= frame;
            bits_left <= nbits;
            phase     <= 1'b0;
            lead      <= 1'b1;
            active    <= 1'b1;
        end else if (active) begin
            if (lead) begin
                mosi <= shreg[FRAME_BITS-1];
                lead <= 1'b0;
            end else if (!phase) begin
                phase <= 1'b1;
            end else begin
                // End of the SCK-high half: sample, then present the next bit.
                phase <= 1'b0;
                if (bits_left <= 6'(DATA_BITS)) begin
                    rx_q <= {rx_q[6:0], miso};
                end
                shreg     <= {shreg[FRAME_BITS-2:0], 1'b0};
                bits_left <= bits_left - 6'd1;
                if (bits_left == 6'd1) begin
                    active <= 1'b0;
                    mosi   <= 1'b0;
                end else begin
                    mosi <= shreg[FRAME_BITS-2];
                end
            end
        end
    end

endmodule

// File: rtl/spi_sram_wb_slave.sv
// Wishbone classic byte slave mapped onto a 23LC1024-class SPI SRAM (mode 0, SCK = clk_i/2).
// Define SPI_SRAM_SEQ_EN to keep CS low between accesses and stream sequential same-direction bytes.
module spi_sram_wb_slave
    import spi_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 24
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    spi_sram_wb_slave_if.slave wb,
    output logic               spi_cs_n_o,
    output logic               spi_sck_o,
    output logic               spi_mosi_o,
    input  logic               spi_miso_i,
    output state_t             dbg_state_o
);

    state_t      state_q, state_d;
    logic        cs_n_q, cs_n_d;
    logic        ack_q, ack_d;
    logic [7:0]  dat_q, dat_d;
    logic        we_q, we_d;
    logic [23:0] adr_q, adr_d;
    logic [7:0]  wdat_q, wdat_d;
    logic        pend_q, pend_d;

    logic                  req;
    logic [ADDR_WIDTH-1:0] adr_raw;
    logic [23:0]           adr_in;
    logic                  sh_load;
    logic [FRAME_BITS-1:0] sh_frame;
    logic [5:0]            sh_nbits;
    logic                  sh_done;
    logic [7:0]            sh_rx;

    assign adr_raw = wb.wbs_adr_i;
    assign adr_in  = 24'(adr_raw);
    // The !ack term stops a request still held in the ack cycle from being taken twice.
    assign req     = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_err_o = 1'b0;
    assign wb.wbs_rty_o = 1'b0;
    assign wb.wbs_dat_o = dat_q;
    assign spi_cs_n_o   = cs_n_q;
    assign dbg_state_o  = state_q;

    spi_sram_shifter u_shifter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load    (sh_load),
        .frame   (sh_frame),
        .nbits   (sh_nbits),
        .miso    (spi_miso_i),
        .sck     (spi_sck_o),
        .mosi    (spi_mosi_o),
        .done    (sh_done),
        .rx_byte (sh_rx)
    );

    always_comb begin
        state_d  = state_q;
        cs_n_d   = cs_n_q;
        ack_d    = 1'b0;
        dat_d    = dat_q;
        we_d     = we_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        pend_d   = pend_q;
        sh_load  = 1'b0;
        sh_frame = '0;
        sh_nbits = 6'(FRAME_BITS);

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    // Request taken earlier in HOLD; the CS-high gap has now elapsed.
                    sh_load  = 1'b1;
                    sh_frame = build_frame(we_q, adr_q, wdat_q);
                    cs_n_d   = 1'b0;
                    pend_d   = 1'b0;
                    state_d  = SHIFT;
                end else if (req) begin
                    we_d     = wb.wbs_we_i;
                    adr_d    = adr_in;
                    wdat_d   = wb.wbs_dat_i;
                    sh_load  = 1'b1;
                    sh_frame = build_frame(wb.wbs_we_i, adr_in, wb.wbs_dat_i);
                    cs_n_d   = 1'b0;
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                if (sh_done) begin
                    ack_d = 1'b1;
                    if (!we_q) begin
                        dat_d = sh_rx;
                    end
`ifdef SPI_SRAM_SEQ_EN
                    state_d = HOLD;
`else
                    cs_n_d  = 1'b1;
                    state_d = DONE;
`endif
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            HOLD: begin
`ifdef SPI_SRAM_SEQ_EN
                if (req) begin
                    we_d   = wb.wbs_we_i;
                    adr_d  = adr_in;
                    wdat_d = wb.wbs_dat_i;
                    if ((wb.wbs_we_i == we_q) && (adr_in == adr_q + 24'd1)) begin
                        // SRAM auto-increments: only the data byte goes on the wire.
                        sh_load  = 1'b1;
                        sh_frame = {(wb.wbs_we_i ? wb.wbs_dat_i : 8'h00), 32'h0};
                        sh_nbits = 6'(DATA_BITS);
                        state_d  = SHIFT;
                    end else begin
                        cs_n_d  = 1'b1;
                        pend_d  = 1'b1;
                        state_d = DONE;
                    end
                end
`else
                state_d = IDLE;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            ack_q   <= 1'b0;
            dat_q   <= 8'h00;
            we_q    <= 1'b0;
            adr_q   <= 24'h0;
            wdat_q  <= 8'h00;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_spi_sram_wb_slave.sv
// Bench for spi_sram_wb_slave: behavioural SPI SRAM device, reference memory/latency model, scenario tasks.
// Build with or without SPI_SRAM_SEQ_EN; the reference model follows the same macro.
`timescale 1ns/1ps
module tb_spi_sram_wb_slave;
    import spi_sram_pkg::*;

    localparam int AW = 24;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    spi_sram_wb_slave_if #(.ADDR_WIDTH(AW)) wb ();
    logic   spi_cs_n_o, spi_sck_o, spi_mosi_o, spi_miso_i;
    state_t dbg_state_o;

    spi_sram_wb_slave #(.ADDR_WIDTH(AW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wb          (wb),
        .spi_cs_n_o  (spi_cs_n_o),
        .spi_sck_o   (spi_sck_o),
        .spi_mosi_o  (spi_mosi_o),
        .spi_miso_i  (spi_miso_i),
        .dbg_state_o (dbg_state_o)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // ---------------- bus / pin monitors ----------------
    int          acks_seen = 0;
    int          sck_rises = 0;
    int          cs_viol = 0;
    int          cs_hi_run = 0;
    int          min_gap = 1000;
    logic [39:0] cap = '0;
    int          cap_n = 0;

    always @(negedge clk_i) begin
        if (wb.wbs_ack_o === 1'b1) acks_seen++;
        if (spi_sck_o === 1'b1 && spi_cs_n_o === 1'b1) cs_viol++;
        if (spi_cs_n_o === 1'b1) cs_hi_run++;
        else begin
            if (cs_hi_run > 0 && cs_hi_run < min_gap) min_gap = cs_hi_run;
            cs_hi_run = 0;
        end
    end

    // ---------------- SPI SRAM device model ----------------
    logic [7:0]  mem[int];
    int          sbits = 0;
    logic [31:0] hdr = '0;
    logic [7:0]  sh_in = '0;
    logic [7:0]  out_byte = '0;
    logic [23:0] cur_addr = '0;

    always @(negedge spi_cs_n_o) sbits = 0;

    always @(posedge spi_sck_o) begin
        sck_rises++;
        if (spi_cs_n_o === 1'b0) begin
            cap = {cap[38:0], spi_mosi_o};
            cap_n++;
            if (sbits < 32) hdr = {hdr[30:0], spi_mosi_o};
            else sh_in = {sh_in[6:0], spi_mosi_o};
            sbits++;
            if (sbits == 32) cur_addr = hdr[23:0];
            if (sbits >= 40 && (sbits - 32) % 8 == 0) begin
                if (hdr[31:24] == CMD_WRITE) mem[int'(cur_addr)] = sh_in;
                cur_addr = cur_addr + 24'd1;
            end
        end
    end

    always @(negedge spi_sck_o) begin
        int idx;
        if (spi_cs_n_o === 1'b0 && sbits >= 32 && hdr[31:24] == CMD_READ) begin
            idx = (sbits - 32) % 8;
            if (idx == 0) out_byte = mem.exists(int'(cur_addr)) ? mem[int'(cur_addr)] : 8'h00;
            spi_miso_i = out_byte[7-idx];
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem[int];
    logic [7:0]  last_rd = 8'h00;
    bit          hold_valid = 1'b0;
    logic        hold_we = 1'b0;
    logic [23:0] hold_addr = '0;
    logic [7:0]  exp_q[$];

    task automatic preload(input logic [23:0] adr, input logic [7:0] val);
        mem[int'(adr)]     = val;
        ref_mem[int'(adr)] = val;
    endtask

    task automatic model_reset();
        hold_valid = 1'b0;
        last_rd    = 8'h00;
    endtask

    task automatic drop_req();
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
    endtask

    // ---------------- driver: one Wishbone transfer with inline checks ----------------
    task automatic do_xfer(input logic we, input logic [23:0] adr, input logic [7:0] dat,
                           input bit hold_extra, input bit scramble);
        int          exp_lat, exp_bits, lat;
        logic [39:0] exp_frame, mask;
        logic [7:0]  exp_rd, popped;
        logic        exp_cs_after;
        state_t      exp_rest;
        bit          got;

        if (hold_valid && we == hold_we && adr == hold_addr + 24'd1) begin
            exp_lat   = 17;
            exp_bits  = 8;
            exp_frame = {32'h0, (we ? dat : 8'h00)};
        end else begin
            exp_lat   = hold_valid ? 83 : 81;
            exp_bits  = 40;
            exp_frame = {(we ? CMD_WRITE : CMD_READ), adr, (we ? dat : 8'h00)};
        end
`ifdef SPI_SRAM_SEQ_EN
        exp_cs_after = 1'b0;
        exp_rest     = HOLD;
`else
        exp_cs_after = 1'b1;
        exp_rest     = IDLE;
`endif
        mask = (exp_bits == 8) ? 40'hFF : {40{1'b1}};
        exp_rd = 8'h00;
        if (!we) begin
            exp_rd = ref_mem.exists(int'(adr)) ? ref_mem[int'(adr)] : 8'h00;
            exp_q.push_back(exp_rd);
        end

        @(negedge clk_i);
        cap = '0;
        cap_n = 0;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;

        got = 1'b0;
        lat = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(posedge clk_i);
            #1;
            if (wb.wbs_ack_o === 1'b1) begin
                got = 1'b1;
                lat = n;
            end else if (n == 0 && scramble) begin
                wb.wbs_adr_i = 24'($urandom);
                wb.wbs_dat_i = 8'($urandom);
                wb.wbs_we_i  = 1'($urandom);
            end
        end

        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL ack_timeout: no ack within 300 edges, adr=%06h we=%0b", adr, we);
            drop_req();
            if (!we) popped = exp_q.pop_back();
            return;
        end
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL ack_latency: got %0d edges, want %0d (adr=%06h we=%0b)", lat, exp_lat, adr, we);
        end

        n_cmp++;
        if (cap_n != exp_bits) begin
            n_fail++;
            $display("FAIL frame_len: got %0d bits, want %0d (adr=%06h)", cap_n, exp_bits, adr);
        end
        n_cmp++;
        if ((cap & mask) !== exp_frame) begin
            n_fail++;
            $display("FAIL frame_bits: got %010h, want %010h", cap & mask, exp_frame);
        end

        n_cmp++;
        if (!we) begin
            popped = exp_q.pop_front();
            if (wb.wbs_dat_o !== popped) begin
                n_fail++;
                $display("FAIL read_data: got %02h, want %02h (adr=%06h)", wb.wbs_dat_o, popped, adr);
            end
        end else if (wb.wbs_dat_o !== last_rd) begin
            n_fail++;
            $display("FAIL dat_o_kept_on_write: got %02h, want %02h", wb.wbs_dat_o, last_rd);
        end

        if (!hold_extra) drop_req();
        @(posedge clk_i);
        #1;
        n_cmp++;
        if (wb.wbs_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_single_cycle: got %0b, want 0", wb.wbs_ack_o);
        end
        n_cmp++;
        if (spi_cs_n_o !== exp_cs_after) begin
            n_fail++;
            $display("FAIL cs_after_ack: got %0b, want %0b", spi_cs_n_o, exp_cs_after);
        end

        if (hold_extra) begin
            drop_req();
            repeat (3) @(posedge clk_i);
            #1;
            n_cmp++;
            if (dbg_state_o !== exp_rest || spi_cs_n_o !== exp_cs_after) begin
                n_fail++;
                $display("FAIL held_req_reaccepted: state %0d cs_n %0b, want state %0d cs_n %0b",
                         int'(dbg_state_o), spi_cs_n_o, int'(exp_rest), exp_cs_after);
            end
        end

        if (we) ref_mem[int'(adr)] = dat;
        else last_rd = exp_rd;
`ifdef SPI_SRAM_SEQ_EN
        hold_valid = 1'b1;
        hold_we    = we;
        hold_addr  = adr;
`endif
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int base;
        rst_ni = 1'b1;
        #1;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (wb.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %0b want 0", wb.wbs_ack_o); end
        n_cmp++; if (spi_cs_n_o !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n: got %0b want 1", spi_cs_n_o); end
        n_cmp++; if (spi_sck_o !== 1'b0) begin n_fail++; $display("FAIL rst_sck: got %0b want 0", spi_sck_o); end
        n_cmp++; if (spi_mosi_o !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %0b want 0", spi_mosi_o); end
        n_cmp++; if (wb.wbs_dat_o !== 8'h00) begin n_fail++; $display("FAIL rst_dat_o: got %02h want 00", wb.wbs_dat_o); end
        n_cmp++; if (dbg_state_o !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", int'(dbg_state_o), int'(IDLE)); end
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        base = sck_rises;
        repeat (100) @(posedge clk_i);
        #1;
        n_cmp++; if (sck_rises != base) begin n_fail++; $display("FAIL idle_sck: got %0d rises want %0d", sck_rises, base); end
        n_cmp++; if (spi_cs_n_o !== 1'b1) begin n_fail++; $display("FAIL idle_cs_n: got %0b want 1", spi_cs_n_o); end
        n_cmp++; if (wb.wbs_err_o !== 1'b0 || wb.wbs_rty_o !== 1'b0) begin
            n_fail++; $display("FAIL err_rty: got %0b/%0b want 0/0", wb.wbs_err_o, wb.wbs_rty_o);
        end
    endtask

    task automatic test_write();
        do_xfer(1'b1, 24'h000010, 8'h5A, 1'b0, 1'b0);
        n_cmp++;
        if (!mem.exists(32'h10) || mem[32'h10] !== 8'h5A) begin
            n_fail++; $display("FAIL sram_write: byte at 000010 not 5A");
        end
    endtask

    task automatic test_read();
        preload(24'h7FFFFF, 8'hA5);
        do_xfer(1'b0, 24'h7FFFFF, 8'h33, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int base;
        base = acks_seen;
        preload(24'h001000, 8'($urandom));
        preload(24'h004020, 8'($urandom));
        do_xfer(1'b0, 24'h001000, 8'h00, 1'b1, 1'b1);
        do_xfer(1'b0, 24'h004020, 8'h00, 1'b1, 1'b0);
        do_xfer(1'b1, 24'h00C000, 8'($urandom), 1'b1, 1'b1);
        n_cmp++;
        if (acks_seen - base != 3) begin
            n_fail++; $display("FAIL ack_count: got %0d want 3", acks_seen - base);
        end
        n_cmp++;
        if (min_gap < 2) begin
            n_fail++; $display("FAIL cs_gap: got %0d cycles want >=2", min_gap);
        end
    endtask

    task automatic test_reset_mid();
        int  base;
        bit  reached;
        base = acks_seen;
        @(negedge clk_i);
        cap_n = 0;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_adr_i = 24'h0ABCDE;
        wb.wbs_dat_i = 8'hC3;
        reached = 1'b0;
        for (int n = 0; n < 200 && !reached; n++) begin
            @(posedge clk_i);
            #1;
            if (cap_n >= 20) reached = 1'b1;
        end
        n_cmp++;
        if (!reached) begin n_fail++; $display("FAIL mid_reach_bit20: got %0d bits want 20", cap_n); end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (spi_cs_n_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst_cs_n: got %0b want 1", spi_cs_n_o); end
        n_cmp++; if (spi_sck_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sck: got %0b want 0", spi_sck_o); end
        n_cmp++; if (wb.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ack: got %0b want 0", wb.wbs_ack_o); end
        drop_req();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        repeat (4) @(posedge clk_i);
        #1;
        n_cmp++; if (acks_seen != base) begin n_fail++; $display("FAIL mid_rst_no_ack: got %0d acks want 0", acks_seen - base); end
        n_cmp++;
        if (mem.exists(32'h0ABCDE)) begin n_fail++; $display("FAIL mid_rst_no_write: aborted byte was committed"); end
        do_xfer(1'b1, 24'h000321, 8'h96, 1'b0, 1'b0);
        do_xfer(1'b0, 24'h000321, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_seq_stream();
        preload(24'h000100, 8'($urandom));
        preload(24'h000101, 8'($urandom));
        preload(24'h000200, 8'($urandom));
        do_xfer(1'b0, 24'h000100, 8'h00, 1'b0, 1'b0);
        do_xfer(1'b0, 24'h000101, 8'h00, 1'b0, 1'b0);
        do_xfer(1'b0, 24'h000200, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [23:0] adr;
        logic        we;
        adr = 24'h000040;
        we  = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) we = ~we;
            if ($urandom_range(0, 1) == 1) adr = adr + 24'd1;
            else adr = 24'($urandom_range(0, 63));
            if (i == 12) adr = 24'hFFFFFF;
            do_xfer(we, adr, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        spi_miso_i   = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;

        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_seq_stream();
        test_random();

        n_cmp++;
        if (cs_viol != 0) begin n_fail++; $display("FAIL sck_with_cs_high: got %0d cycles want 0", cs_viol); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size()); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
